// File: rtl/if_write_addr_gen_pkg.sv
// Shared definitions for the IF scratchpad write-side address generator.
//   state_t  : FSM state encoding for the write-side controller
//   wrap_inc : pointer increment that wraps at an arbitrary (non power-of-two) depth
package if_write_addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    ROW_DONE = 2'd2
  } state_t;

  // The wrap is an explicit compare so the ring works for any depth, not only powers of two.
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p + 1 >= depth) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/if_ring_ptr.sv
// Wrapping pointer register for the circular IF scratchpad.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the pointer to 0
//   load       : load load_value (has priority over inc)
//   load_value : value to load
//   inc        : advance pointer by one, wrapping at DEPTH
//   ptr        : current pointer value
module if_ring_ptr
  import if_write_addr_gen_pkg::*;
#(
  parameter int ADDR_LEN = 8,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ADDR_LEN-1:0] load_value,
  input  logic                inc,
  output logic [ADDR_LEN-1:0] ptr
);

  logic [ADDR_LEN-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (load) begin
      r_ptr <= load_value;
    end else if (inc) begin
      r_ptr <= ADDR_LEN'(wrap_inc(32'(r_ptr), 32'(DEPTH)));
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/if_write_addr_gen.sv
// IF scratchpad write-side address generator. Accepts a ready/valid word
// stream, writes one row into the circular scratchpad and publishes the
// row window (start, next-free, end) to the read-side address generator.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   in_valid/in_data/in_last/in_ready : upstream word stream
//   row_release        : read side has fully consumed the current row
//   IF_wen/IF_waddr/IF_wdata : scratchpad write port (IF_waddr = next-free slot)
//   IF_start_pos       : slot of the first word of the current row
//   IF_end_pos/IF_end_valid : slot of the last word, valid once it is written
//   row_start          : one-cycle pulse after the first word of a row is written
//   row_overflow       : sticky, a row ran out of scratchpad capacity
//
// state    | meaning
// IDLE     | no word of the next row written yet
// FILL     | row in progress, last word not yet seen
// ROW_DONE | last word written, waiting for the read side to release the row
module if_write_addr_gen
  import if_write_addr_gen_pkg::*;
#(
  parameter int IF_ADDR_LEN      = 8,
  parameter int IF_SCRATCH_DEPTH = 8,
  parameter int IF_SCRATCH_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [IF_SCRATCH_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic                        row_release,
  output logic                        IF_wen,
  output logic [IF_ADDR_LEN-1:0]      IF_waddr,
  output logic [IF_SCRATCH_WIDTH-1:0] IF_wdata,
  output logic [IF_ADDR_LEN-1:0]      IF_start_pos,
  output logic [IF_ADDR_LEN-1:0]      IF_end_pos,
  output logic                        IF_end_valid,
  output logic                        row_start,
  output logic                        row_overflow
);

  localparam int CNT_W = IF_ADDR_LEN + 1;
  // One slot is always kept free so a full row never makes waddr catch up with start.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_SCRATCH_DEPTH - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_count;
  logic [IF_ADDR_LEN-1:0] r_end_pos;
  logic                   r_end_valid;
  logic                   r_row_start;
  logic                   r_overflow;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_release;
  logic [IF_ADDR_LEN-1:0] w_wr_ptr;
  logic [IF_ADDR_LEN-1:0] w_start_pos;

  always_comb begin
    w_ready   = ~rst & (r_state != ROW_DONE) & (r_count < CNT_MAX);
    w_accept  = in_valid & w_ready;
    // A release only counts once the row is complete; strays are dropped.
    w_release = (r_state == ROW_DONE) & row_release;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = in_last ? ROW_DONE : FILL;
      FILL:     if (w_accept & in_last) w_state_nxt = ROW_DONE;
      ROW_DONE: if (w_release) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_end_pos   <= '0;
      r_end_valid <= 1'b0;
      r_row_start <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_start <= (r_state == IDLE) & w_accept;
      if (w_release) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= r_count + 1'b1;
      end
      if (w_accept & in_last) begin
        r_end_pos   <= w_wr_ptr;
        r_end_valid <= 1'b1;
      end else if (w_release) begin
        r_end_valid <= 1'b0;
      end
      // Capacity exhausted without a last word: the block stalls here on purpose.
      if ((r_state == FILL) && (r_count == CNT_MAX)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  if_ring_ptr #(
    .ADDR_LEN (IF_ADDR_LEN),
    .DEPTH    (IF_SCRATCH_DEPTH)
  ) u_wr_ptr (
    .clk        (clk),
    .rst        (rst),
    .load       (1'b0),
    .load_value ('0),
    .inc        (w_accept),
    .ptr        (w_wr_ptr)
  );

  // On release the next row starts at the current next-free slot.
  if_ring_ptr #(
    .ADDR_LEN (IF_ADDR_LEN),
    .DEPTH    (IF_SCRATCH_DEPTH)
  ) u_start_pos (
    .clk        (clk),
    .rst        (rst),
    .load       (w_release),
    .load_value (w_wr_ptr),
    .inc        (1'b0),
    .ptr        (w_start_pos)
  );

  assign in_ready     = w_ready;
  assign IF_wen       = w_accept;
  assign IF_waddr     = w_wr_ptr;
  assign IF_wdata     = in_data;
  assign IF_start_pos = w_start_pos;
  assign IF_end_pos   = r_end_pos;
  assign IF_end_valid = r_end_valid;
  assign row_start    = r_row_start;
  assign row_overflow = r_overflow;

endmodule

// File: tb/tb_if_write_addr_gen.sv
module tb_if_write_addr_gen;

  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          row_release;
  logic          IF_wen;
  logic [AW-1:0] IF_waddr;
  logic [DW-1:0] IF_wdata;
  logic [AW-1:0] IF_start_pos;
  logic [AW-1:0] IF_end_pos;
  logic          IF_end_valid;
  logic          row_start;
  logic          row_overflow;

  if_write_addr_gen #(
    .IF_ADDR_LEN      (AW),
    .IF_SCRATCH_DEPTH (DEPTH),
    .IF_SCRATCH_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .row_release  (row_release),
    .IF_wen       (IF_wen),
    .IF_waddr     (IF_waddr),
    .IF_wdata     (IF_wdata),
    .IF_start_pos (IF_start_pos),
    .IF_end_pos   (IF_end_pos),
    .IF_end_valid (IF_end_valid),
    .row_start    (row_start),
    .row_overflow (row_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ring position of the next free slot and of the row start.
  int m_wptr  = 0;
  int m_start = 0;

  // Scoreboard queues: expected writes {addr,data} and expected row end slots.
  logic [AW+DW-1:0] exp_wq[$];
  int               exp_eq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every end_valid rise is matched against the queues.
  logic prev_end_valid = 1'b0;
  always @(negedge clk) begin
    if (IF_wen) begin
      if (exp_wq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0d data %0d at %0t", IF_waddr, IF_wdata, $time);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_wq.pop_front();
        check("write_addr", 32'(IF_waddr), 32'(e[AW+DW-1:DW]));
        check("write_data", 32'(IF_wdata), 32'(e[DW-1:0]));
      end
    end
    if (IF_end_valid && !prev_end_valid) begin
      if (exp_eq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_end_valid: end_pos %0d at %0t", IF_end_pos, $time);
      end else begin
        check("end_pos", 32'(IF_end_pos), 32'(exp_eq.pop_front()));
      end
    end
    prev_end_valid = IF_end_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one row; optional stray release mid-row, release coincident with the
  // last word, or no last word at all (overflow / mid-row reset scenarios).
  task automatic send_row(input int len, input bit stray_rel, input bit late_rel, input bit no_last);
    for (int i = 0; i < len; i++) begin
      int t;
      in_valid    = 1'b1;
      in_data     = DW'($urandom);
      in_last     = !no_last && (i == len - 1);
      row_release = (stray_rel && i == 2) || (late_rel && in_last);
      exp_wq.push_back({AW'(m_wptr), in_data});
      if (in_last) exp_eq.push_back(m_wptr);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: word %0d of row not accepted", i);
      end
      tick();
      m_wptr = (m_wptr + 1) % DEPTH;
      if (i == 0) check("row_start_pulse", 32'(row_start), 1);
      if (i == 1) check("row_start_single", 32'(row_start), 0);
      if (len == 1 && !no_last) check("single_end_valid", 32'(IF_end_valid), 1);
      in_valid    = 1'b0;
      in_last     = 1'b0;
      row_release = 1'b0;
      if (i < len - 1 && $urandom_range(0, 3) == 0) tick();
    end
    if (!no_last) begin
      check("done_end_valid", 32'(IF_end_valid), 1);
      check("done_in_ready", 32'(in_ready), 0);
      repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      check("held_end_valid", 32'(IF_end_valid), 1);
      check("held_no_ready", 32'(in_ready), 0);
      in_valid    = 1'b0;
      row_release = 1'b1;
      tick();
      row_release = 1'b0;
      m_start     = m_wptr;
      check("release_start_pos", 32'(IF_start_pos), 32'(m_start));
      check("release_end_valid", 32'(IF_end_valid), 0);
      check("release_in_ready", 32'(in_ready), 1);
      check("release_waddr", 32'(IF_waddr), 32'(m_wptr));
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_data     = '0;
    in_last     = 1'b0;
    row_release = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wen", 32'(IF_wen), 0);
    check("rst_waddr", 32'(IF_waddr), 0);
    check("rst_start_pos", 32'(IF_start_pos), 0);
    check("rst_end_pos", 32'(IF_end_pos), 0);
    check("rst_end_valid", 32'(IF_end_valid), 0);
    check("rst_row_start", 32'(row_start), 0);
    check("rst_overflow", 32'(row_overflow), 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // Basic row then a wrapping row.
    send_row(4, 1'b0, 1'b0, 1'b0);
    check("basic_start_pos", 32'(IF_start_pos), 4);
    send_row(6, 1'b0, 1'b0, 1'b0);
    check("wrap_start_pos", 32'(IF_start_pos), 2);
    send_row(1, 1'b0, 1'b0, 1'b0);
    send_row(5, 1'b1, 1'b1, 1'b0);
    send_row(7, 1'b0, 1'b0, 1'b0);

    // Overflow: seven words, no last.
    send_row(7, 1'b0, 1'b0, 1'b1);
    check("ovf_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) tick();
    check("ovf_flag", 32'(row_overflow), 1);
    check("ovf_stall_ready", 32'(in_ready), 0);
    row_release = 1'b1;
    tick();
    row_release = 1'b0;
    check("ovf_sticky", 32'(row_overflow), 1);
    check("ovf_end_valid", 32'(IF_end_valid), 0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    m_wptr   = 0;
    m_start  = 0;
    #1;
    check("ovf_cleared", 32'(row_overflow), 0);
    check("ovf_rst_ready", 32'(in_ready), 1);

    // Reset mid-row with in_valid held high.
    send_row(3, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    check("midrst_waddr", 32'(IF_waddr), 0);
    check("midrst_ready", 32'(in_ready), 0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    m_wptr   = 0;
    m_start  = 0;
    #1;
    check("midrst_start_pos", 32'(IF_start_pos), 0);
    check("midrst_end_valid", 32'(IF_end_valid), 0);
    check("midrst_ready_after", 32'(in_ready), 1);

    // Randomized rows.
    for (int r = 0; r < 40; r++) begin
      send_row($urandom_range(1, DEPTH - 1), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) tick();
    check("writes_drained", 32'(exp_wq.size()), 0);
    check("ends_drained", 32'(exp_eq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
